// File: rtl/spm_result_collector.sv
// Collects per-pass SPM bank beats into one complete vector response for writeback.
// Optional protocol checker enabled by defining SPM_COLLECTOR_CHECK_EN.
module spm_result_collector #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ID_W-1:0]         in_id_i,
    input  logic                    in_is_store_i,
    input  logic [LANES-1:0]        in_satisfied_mask_i,
    input  logic [LANES-1:0]        in_still_pending_mask_i,
    input  logic [LANES*DATA_W-1:0] in_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ID_W-1:0]         out_id_o,
    output logic                    out_is_store_o,
    output logic [LANES-1:0]        out_lane_mask_o,
    output logic [LANES*DATA_W-1:0] out_data_o,
    output logic                    busy_o
`ifdef SPM_COLLECTOR_CHECK_EN
    ,
    output logic                    protocol_error_o
`endif
);

    localparam int unsigned VEC_W = LANES * DATA_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             is_store_q, is_store_d;
    logic [LANES-1:0] lane_acc_q, lane_acc_d;
    logic [VEC_W-1:0] data_acc_q, data_acc_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             accept_c;
    logic             last_beat_c;
    logic [LANES-1:0] lane_base_c;
    logic [VEC_W-1:0] data_base_c;

    // Next-state, capture and merge logic
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        is_store_d  = is_store_q;
        lane_base_c = lane_acc_q;
        data_base_c = data_acc_q;
        accept_c    = in_valid_i && in_ready_q;
        last_beat_c = (in_still_pending_mask_i == '0);

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    id_d        = in_id_i;
                    is_store_d  = in_is_store_i;
                    lane_base_c = '0;
                    data_base_c = '0;
                    state_d     = last_beat_c ? ST_OUTPUT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept_c) begin
                    state_d = last_beat_c ? ST_OUTPUT : ST_COLLECT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        lane_acc_d = lane_base_c;
        data_acc_d = data_base_c;
        if (accept_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (in_satisfied_mask_i[i]) begin
                    lane_acc_d[i] = 1'b1;
                    data_acc_d[i*DATA_W +: DATA_W] =
                        in_is_store_i ? DATA_W'(0) : in_data_i[i*DATA_W +: DATA_W];
                end
            end
        end

        in_ready_d  = (state_d != ST_OUTPUT);
        out_valid_d = (state_d == ST_OUTPUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            is_store_q  <= 1'b0;
            lane_acc_q  <= '0;
            data_acc_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            is_store_q  <= is_store_d;
            lane_acc_q  <= lane_acc_d;
            data_acc_q  <= data_acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SPM_COLLECTOR_CHECK_EN
    logic err_q, err_d;
    logic err_hit_c;

    // Sticky flag: tag drift inside a request, pending/served overlap, or a lane served twice
    always_comb begin
        err_hit_c = 1'b0;
        if (accept_c) begin
            if ((state_q == ST_COLLECT) &&
                ((in_id_i != id_q) || (in_is_store_i != is_store_q))) begin
                err_hit_c = 1'b1;
            end
            if ((in_satisfied_mask_i & in_still_pending_mask_i) != '0) begin
                err_hit_c = 1'b1;
            end
            if ((in_satisfied_mask_i & lane_base_c) != '0) begin
                err_hit_c = 1'b1;
            end
        end
        err_d = err_q | err_hit_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign protocol_error_o = err_q;
`endif

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_id_o        = id_q;
    assign out_is_store_o  = is_store_q;
    assign out_lane_mask_o = lane_acc_q;
    assign out_data_o      = data_acc_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_spm_result_collector.sv
// Directed scoreboard bench for spm_result_collector; responses predicted from driven beats.
module tb_spm_result_collector;

    localparam int unsigned LANES  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned VW     = LANES * DATA_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [ID_W-1:0]  in_id_i;
    logic             in_is_store_i;
    logic [LANES-1:0] in_satisfied_mask_i;
    logic [LANES-1:0] in_still_pending_mask_i;
    logic [VW-1:0]    in_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [ID_W-1:0]  out_id_o;
    logic             out_is_store_o;
    logic [LANES-1:0] out_lane_mask_o;
    logic [VW-1:0]    out_data_o;
    logic             busy_o;
`ifdef SPM_COLLECTOR_CHECK_EN
    logic             protocol_error_o;
`endif

    spm_result_collector #(.LANES(LANES), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_valid_i              (in_valid_i),
        .in_ready_o              (in_ready_o),
        .in_id_i                 (in_id_i),
        .in_is_store_i           (in_is_store_i),
        .in_satisfied_mask_i     (in_satisfied_mask_i),
        .in_still_pending_mask_i (in_still_pending_mask_i),
        .in_data_i               (in_data_i),
        .out_valid_o             (out_valid_o),
        .out_ready_i             (out_ready_i),
        .out_id_o                (out_id_o),
        .out_is_store_o          (out_is_store_o),
        .out_lane_mask_o         (out_lane_mask_o),
        .out_data_o              (out_data_o),
        .busy_o                  (busy_o)
`ifdef SPM_COLLECTOR_CHECK_EN
        ,
        .protocol_error_o        (protocol_error_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic             st;
        logic [LANES-1:0] mask;
        logic [VW-1:0]    data;
    } rsp_t;

    rsp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the request being assembled
    logic             m_idle;
    logic [ID_W-1:0]  m_id;
    logic             m_st;
    logic [LANES-1:0] m_mask;
    logic [VW-1:0]    m_data;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] idx_data();
        logic [VW-1:0] d;
        for (int i = 0; i < int'(LANES); i++) d[i*DATA_W +: DATA_W] = DATA_W'(i);
        return d;
    endfunction

    function automatic logic [VW-1:0] rnd_data();
        logic [VW-1:0] d;
        for (int i = 0; i < int'(LANES); i++) d[i*DATA_W +: DATA_W] = $urandom;
        return d;
    endfunction

    // Drive one beat at a falling edge; it transfers on the following rising edge
    task automatic send_beat(input logic [ID_W-1:0] id, input logic st,
                             input logic [LANES-1:0] sat, input logic [LANES-1:0] pend,
                             input logic [VW-1:0] data);
        rsp_t r;
        in_valid_i = 1'b1;
        in_id_i = id;
        in_is_store_i = st;
        in_satisfied_mask_i = sat;
        in_still_pending_mask_i = pend;
        in_data_i = data;
        chk("in_ready_on_beat", VW'(in_ready_o), VW'(1));
        if (m_idle) begin
            m_id = id;
            m_st = st;
            m_mask = '0;
            m_data = '0;
        end
        for (int i = 0; i < int'(LANES); i++) begin
            if (sat[i]) begin
                m_mask[i] = 1'b1;
                m_data[i*DATA_W +: DATA_W] = st ? DATA_W'(0) : data[i*DATA_W +: DATA_W];
            end
        end
        if (pend == '0) begin
            r.id = m_id; r.st = m_st; r.mask = m_mask; r.data = m_data;
            sb.push_back(r);
            m_idle = 1'b1;
        end else begin
            m_idle = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    // Compare the presented response with the scoreboard head, then hand it off
    task automatic check_rsp();
        rsp_t e;
        chk("sb_nonempty", VW'(sb.size() != 0), VW'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_valid", VW'(out_valid_o), VW'(1));
            chk("out_id", VW'(out_id_o), VW'(e.id));
            chk("out_is_store", VW'(out_is_store_o), VW'(e.st));
            chk("out_lane_mask", VW'(out_lane_mask_o), VW'(e.mask));
            chk("out_data", out_data_o, e.data);
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("out_valid_drop", VW'(out_valid_o), VW'(0));
        chk("busy_idle", VW'(busy_o), VW'(0));
        chk("in_ready_idle", VW'(in_ready_o), VW'(1));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, VW'(out_valid_o), VW'(0));
        chk({tag, "_in_ready"}, VW'(in_ready_o), VW'(1));
        chk({tag, "_busy"}, VW'(busy_o), VW'(0));
        chk({tag, "_out_id"}, VW'(out_id_o), VW'(0));
        chk({tag, "_out_is_store"}, VW'(out_is_store_o), VW'(0));
        chk({tag, "_mask"}, VW'(out_lane_mask_o), VW'(0));
        chk({tag, "_data"}, out_data_o, VW'(0));
`ifdef SPM_COLLECTOR_CHECK_EN
        chk({tag, "_perr"}, VW'(protocol_error_o), VW'(0));
`endif
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state(tag);
        sb.delete();
        m_idle = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [VW-1:0] d1, d2, d3, hold;
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        in_id_i = '0;
        in_is_store_i = 1'b0;
        in_satisfied_mask_i = '0;
        in_still_pending_mask_i = '0;
        in_data_i = '0;
        out_ready_i = 1'b0;
        m_idle = 1'b1;
        m_id = '0; m_st = 1'b0; m_mask = '0; m_data = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single-pass load
        send_beat(8'h12, 1'b0, 16'hFFFF, 16'h0000, idx_data());
        check_rsp();

        // 2: three-pass load, lanes from their own pass
        d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
        send_beat(8'h21, 1'b0, 16'h00FF, 16'hFF00, d1);
        chk("p2_busy", VW'(busy_o), VW'(1));
        chk("p2_no_out1", VW'(out_valid_o), VW'(0));
        send_beat(8'h21, 1'b0, 16'h0F00, 16'hF000, d2);
        chk("p2_no_out2", VW'(out_valid_o), VW'(0));
        send_beat(8'h21, 1'b0, 16'hF000, 16'h0000, d3);
        check_rsp();

        // 3: backpressure holds response, blocks beats
        send_beat(8'h33, 1'b0, 16'hA5A5, 16'h0000, rnd_data());
        hold = sb[0].data;
        in_valid_i = 1'b1;
        in_id_i = 8'h77;
        in_satisfied_mask_i = 16'hFFFF;
        in_still_pending_mask_i = 16'h0000;
        in_data_i = '1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", VW'(out_valid_o), VW'(1));
            chk("bp_data_held", out_data_o, hold);
            chk("bp_in_ready", VW'(in_ready_o), VW'(0));
        end
        in_valid_i = 1'b0;
        check_rsp();
        send_beat(8'h34, 1'b0, 16'h0001, 16'h0000, rnd_data());
        check_rsp();

        // 4: store zeroes data
        send_beat(8'h44, 1'b1, 16'hFFFF, 16'h0000, '1);
        check_rsp();

        // Empty satisfied beat closes request; earlier lanes kept
        send_beat(8'h55, 1'b0, 16'h0030, 16'h00C0, rnd_data());
        send_beat(8'h55, 1'b0, 16'h0000, 16'h0000, rnd_data());
        check_rsp();
`ifdef SPM_COLLECTOR_CHECK_EN
        chk("perr_clean", VW'(protocol_error_o), VW'(0));
`endif

        // Lane served twice: last write wins
        send_beat(8'h66, 1'b0, 16'h000F, 16'h00F0, rnd_data());
        send_beat(8'h66, 1'b0, 16'h00F3, 16'h0000, rnd_data());
        check_rsp();

        // 5: reset mid-collect drops partial request
        send_beat(8'h70, 1'b0, 16'h000F, 16'h00F0, rnd_data());
        apply_reset("midreset");
        send_beat(8'h71, 1'b0, 16'h0300, 16'h0000, rnd_data());
        check_rsp();

`ifdef SPM_COLLECTOR_CHECK_EN
        // 6: id mismatch flags error, response still emitted
        apply_reset("chk_rst1");
        send_beat(8'h12, 1'b0, 16'h00FF, 16'hFF00, rnd_data());
        chk("perr_before", VW'(protocol_error_o), VW'(0));
        send_beat(8'h13, 1'b0, 16'hFF00, 16'h0000, rnd_data());
        chk("perr_id", VW'(protocol_error_o), VW'(1));
        check_rsp();
        repeat (3) @(negedge clk);
        chk("perr_sticky", VW'(protocol_error_o), VW'(1));

        // 6: overlap with already-served lane
        apply_reset("chk_rst2");
        send_beat(8'h12, 1'b0, 16'h00FF, 16'hFF00, rnd_data());
        chk("perr_before2", VW'(protocol_error_o), VW'(0));
        send_beat(8'h12, 1'b0, 16'hFF01, 16'h0000, rnd_data());
        chk("perr_overlap", VW'(protocol_error_o), VW'(1));
        check_rsp();
`endif

        chk("sb_drained", VW'(sb.size()), VW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
